// File: rtl/serial_pkg.sv
// Shared types and width helpers for the serial transmit scheduler.
// No logic of its own; the width helpers keep every counter at least one bit wide.
package serial_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      GAP   = 2'd3
   } state_e;

   function automatic int bit_cnt_w(input int size);
      return (size > 2) ? $clog2(size) : 1;
   endfunction

   function automatic int gap_cnt_w(input int gap);
      return (gap > 0) ? $clog2(gap + 1) : 1;
   endfunction

endpackage

// File: rtl/parallel_to_serial.sv
// Parallel-load, MSB-first shift register; loads in one cycle, otherwise shifts zeros in.
// No backpressure: a load pulse always overwrites the current contents.
module ParallelToSerial #(
   parameter int SIZE = 8
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            parallel_ready,
   input  logic [SIZE-1:0] parallel,
   output logic            serial
);

   logic [SIZE-1:0] shreg_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         shreg_q <= '0;
      end else if (parallel_ready) begin
         shreg_q <= parallel;
      end else begin
         shreg_q <= {shreg_q[SIZE-2:0], 1'b0};
      end
   end

   assign serial = shreg_q[SIZE-1];

endmodule

// File: rtl/serial_tx_scheduler_arb.sv
// Round-robin arbiter: combinational one-hot grant searched from pointer+1, wrapping.
// Pointer moves to the winner only on advance; requester 0 wins first after reset.
module rr_arbiter #(
   parameter int N = 2
) (
   input  logic                 clk_i,
   input  logic                 rstn_i,
   input  logic [N-1:0]         req_i,
   input  logic                 advance_i,
   output logic [N-1:0]         grant_o,
   output logic [$clog2(N)-1:0] idx_o
);

   localparam int IDX_W = $clog2(N);

   logic [IDX_W-1:0] ptr_q;

   always_comb begin
      int  cand;
      logic found;
      grant_o = '0;
      idx_o   = '0;
      found   = 1'b0;
      cand    = 0;
      for (int i = 1; i <= N; i++) begin
         cand = int'(ptr_q) + i;
         if (cand >= N) cand = cand - N;
         if (!found && req_i[cand]) begin
            found         = 1'b1;
            grant_o[cand] = 1'b1;
            idx_o         = IDX_W'(cand);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         ptr_q <= IDX_W'(N - 1);
      end else if (advance_i) begin
         ptr_q <= idx_o;
      end
   end

endmodule

// File: rtl/serial_tx_scheduler.sv
// Shares one shifter between NUM_REQ producers: accept in IDLE, LOAD, SIZE SHIFT cycles, GAP.
// Latency transfer->MSB is 2 cycles; producers are held off (ready low) outside IDLE or when disabled.
module serial_tx_scheduler
   import serial_pkg::*;
#(
   parameter int SIZE       = 8,
   parameter int NUM_REQ    = 2,
   parameter int GAP_CYCLES = 1
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       enable,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [NUM_REQ*SIZE-1:0]    req_data,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic                       serial,
   output logic                       frame,
   output logic                       busy,
   output logic                       done,
   output logic [$clog2(NUM_REQ)-1:0] grant_id
);

   localparam int ID_W      = $clog2(NUM_REQ);
   localparam int BIT_CNT_W = bit_cnt_w(SIZE);
   localparam int GAP_CNT_W = gap_cnt_w(GAP_CYCLES);
   localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(SIZE - 1);
   localparam logic [BIT_CNT_W-1:0] BIT_PENULT = BIT_CNT_W'(SIZE - 2);
   localparam logic [GAP_CNT_W-1:0] GAP_LAST = GAP_CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   state_e                 state_q;
   logic [BIT_CNT_W-1:0]   bit_cnt_q;
   logic [GAP_CNT_W-1:0]   gap_cnt_q;
   logic [SIZE-1:0]        word_q;
   logic [SIZE-1:0]        word_d;
   logic [ID_W-1:0]        grant_id_q;
   logic                   load_q;
   logic                   frame_q;
   logic                   busy_q;
   logic                   done_q;

   logic [NUM_REQ-1:0]     arb_grant;
   logic [ID_W-1:0]        arb_idx;
   logic                   transfer;

   assign transfer  = (state_q == IDLE) && enable && (|req_valid);
   assign req_ready = transfer ? arb_grant : '0;
   assign word_d    = req_data[int'(arb_idx)*SIZE +: SIZE];

   rr_arbiter #(.N(NUM_REQ)) u_arb (
      .clk_i     (clk),
      .rstn_i    (rstn),
      .req_i     (req_valid),
      .advance_i (transfer),
      .grant_o   (arb_grant),
      .idx_o     (arb_idx)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= IDLE;
         bit_cnt_q  <= '0;
         gap_cnt_q  <= '0;
         word_q     <= '0;
         grant_id_q <= '0;
         load_q     <= 1'b0;
         frame_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (transfer) begin
                  word_q     <= word_d;
                  grant_id_q <= arb_idx;
                  load_q     <= 1'b1;
                  busy_q     <= 1'b1;
                  state_q    <= LOAD;
               end
            end
            LOAD: begin
               load_q    <= 1'b0;
               frame_q   <= 1'b1;
               bit_cnt_q <= '0;
               state_q   <= SHIFT;
            end
            SHIFT: begin
               if (bit_cnt_q == BIT_LAST) begin
                  frame_q   <= 1'b0;
                  done_q    <= 1'b0;
                  bit_cnt_q <= '0;
                  if (GAP_CYCLES > 0) begin
                     state_q <= GAP;
                  end else begin
                     busy_q  <= 1'b0;
                     state_q <= IDLE;
                  end
               end else begin
                  bit_cnt_q <= bit_cnt_q + BIT_CNT_W'(1);
                  // done is registered, so raise it one cycle ahead to land on the LSB
                  done_q    <= (bit_cnt_q == BIT_PENULT);
               end
            end
            GAP: begin
               if (gap_cnt_q == GAP_LAST) begin
                  gap_cnt_q <= '0;
                  busy_q    <= 1'b0;
                  state_q   <= IDLE;
               end else begin
                  gap_cnt_q <= gap_cnt_q + GAP_CNT_W'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   ParallelToSerial #(.SIZE(SIZE)) u_p2s (
      .clk            (clk),
      .rstn           (rstn),
      .parallel_ready (load_q),
      .parallel       (word_q),
      .serial         (serial)
   );

   assign frame    = frame_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign grant_id = grant_id_q;

endmodule

// File: tb/tb_serial_tx_scheduler.sv
// Scoreboard bench: expected bits and grant ids are queued at each handshake and popped as frame bits appear.
module tb_serial_tx_scheduler;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // DUT A: SIZE 8, NUM_REQ 2, GAP 1
   logic       a_en, a_en_next;
   logic [1:0] a_valid, a_ready;
   logic [15:0] a_data;
   logic       a_serial, a_frame, a_busy, a_done;
   logic [0:0] a_gid;
   // DUT B: SIZE 8, NUM_REQ 2, GAP 0
   logic       b_en;
   logic [1:0] b_valid, b_ready;
   logic [15:0] b_data;
   logic       b_serial, b_frame, b_busy, b_done;
   logic [0:0] b_gid;
   // DUT C: SIZE 2, NUM_REQ 3, GAP 1
   logic       c_en;
   logic [2:0] c_valid, c_ready;
   logic [5:0] c_data;
   logic       c_serial, c_frame, c_busy, c_done;
   logic [1:0] c_gid;
   // DUT D: SIZE 16, NUM_REQ 2, GAP 1
   logic       d_en;
   logic [1:0] d_valid, d_ready;
   logic [31:0] d_data;
   logic       d_serial, d_frame, d_busy, d_done;
   logic [0:0] d_gid;

   serial_tx_scheduler #(.SIZE(8), .NUM_REQ(2), .GAP_CYCLES(1)) u_a (
      .clk(clk), .rstn(rstn), .enable(a_en), .req_valid(a_valid), .req_data(a_data),
      .req_ready(a_ready), .serial(a_serial), .frame(a_frame), .busy(a_busy), .done(a_done),
      .grant_id(a_gid));
   serial_tx_scheduler #(.SIZE(8), .NUM_REQ(2), .GAP_CYCLES(0)) u_b (
      .clk(clk), .rstn(rstn), .enable(b_en), .req_valid(b_valid), .req_data(b_data),
      .req_ready(b_ready), .serial(b_serial), .frame(b_frame), .busy(b_busy), .done(b_done),
      .grant_id(b_gid));
   serial_tx_scheduler #(.SIZE(2), .NUM_REQ(3), .GAP_CYCLES(1)) u_c (
      .clk(clk), .rstn(rstn), .enable(c_en), .req_valid(c_valid), .req_data(c_data),
      .req_ready(c_ready), .serial(c_serial), .frame(c_frame), .busy(c_busy), .done(c_done),
      .grant_id(c_gid));
   serial_tx_scheduler #(.SIZE(16), .NUM_REQ(2), .GAP_CYCLES(1)) u_d (
      .clk(clk), .rstn(rstn), .enable(d_en), .req_valid(d_valid), .req_data(d_data),
      .req_ready(d_ready), .serial(d_serial), .frame(d_frame), .busy(d_busy), .done(d_done),
      .grant_id(d_gid));

   // Producer queues and scoreboard for DUT A
   logic [7:0] a_q0[$];
   logic [7:0] a_q1[$];
   logic       a_exp[$];
   int         a_exp_gid[$];
   int         a_glog[$];

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: time limit hit, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "timeout");
   end

   task automatic do_reset();
      a_q0.delete(); a_q1.delete(); a_exp.delete(); a_exp_gid.delete(); a_glog.delete();
      a_en_next = 1'b0; a_en = 1'b0; a_valid = '0; a_data = '0;
      b_en = 1'b0; b_valid = '0; b_data = '0;
      c_en = 1'b0; c_valid = '0; c_data = '0;
      d_en = 1'b0; d_valid = '0; d_data = '0;
      @(posedge clk); #1 rstn = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk); rstn = 1'b1;
   endtask

   // Drives A's producers after the edge, samples at the falling edge, logs any handshake.
   task automatic a_cycle();
      logic [7:0] w;
      @(posedge clk); #1;
      a_en       = a_en_next;
      a_valid[0] = (a_q0.size() != 0);
      a_valid[1] = (a_q1.size() != 0);
      a_data     = '0;
      if (a_q0.size() != 0) a_data[7:0]  = a_q0[0];
      if (a_q1.size() != 0) a_data[15:8] = a_q1[0];
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         if (a_valid[i] && a_ready[i]) begin
            if (i == 0) w = a_q0.pop_front(); else w = a_q1.pop_front();
            for (int b = 7; b >= 0; b--) a_exp.push_back(w[b]);
            a_exp_gid.push_back(i);
            a_glog.push_back(i);
         end
      end
   endtask

   task automatic test_reset();
      a_en = 1'b0; a_en_next = 1'b0; a_valid = '0; a_data = '0;
      b_en = 1'b0; b_valid = '0; b_data = '0;
      c_en = 1'b0; c_valid = '0; c_data = '0;
      d_en = 1'b0; d_valid = '0; d_data = '0;
      rstn = 1'b0;
      @(negedge clk);
      checks++;
      if ({a_ready, a_serial, a_frame, a_busy, a_done, a_gid} !== 7'b0)
         $display("FAIL reset_a: got %b expected 0", {a_ready, a_serial, a_frame, a_busy, a_done, a_gid});
      checks++;
      if ({b_ready, b_serial, b_frame, b_busy, b_done, b_gid} !== 7'b0)
         $display("FAIL reset_b: got %b expected 0", {b_ready, b_serial, b_frame, b_busy, b_done, b_gid});
      checks++;
      if ({c_ready, c_serial, c_frame, c_busy, c_done, c_gid} !== 9'b0)
         $display("FAIL reset_c: got %b expected 0", {c_ready, c_serial, c_frame, c_busy, c_done, c_gid});
      checks++;
      if ({d_ready, d_serial, d_frame, d_busy, d_done, d_gid} !== 7'b0)
         $display("FAIL reset_d: got %b expected 0", {d_ready, d_serial, d_frame, d_busy, d_done, d_gid});
      if ({a_ready, a_serial, a_frame, a_busy, a_done, a_gid} !== 7'b0) errors++;
      if ({b_ready, b_serial, b_frame, b_busy, b_done, b_gid} !== 7'b0) errors++;
      if ({c_ready, c_serial, c_frame, c_busy, c_done, c_gid} !== 9'b0) errors++;
      if ({d_ready, d_serial, d_frame, d_busy, d_done, d_gid} !== 7'b0) errors++;
      @(negedge clk); rstn = 1'b1;
   endtask

   task automatic test_single();
      logic eb;
      do_reset();
      a_en_next = 1'b1;
      a_q0.push_back(8'hA5);
      a_cycle();
      checks++;
      if (a_ready !== 2'b01) begin errors++; $display("FAIL single_ready: got %b expected 01", a_ready); end
      for (int k = 1; k <= 12; k++) begin
         a_cycle();
         checks++;
         if (a_frame !== (k >= 2 && k <= 9)) begin
            errors++; $display("FAIL single_frame k=%0d: got %b", k, a_frame);
         end
         if (a_frame && a_exp.size() != 0) begin
            eb = a_exp.pop_front();
            checks++;
            if (a_serial !== eb) begin errors++; $display("FAIL single_bit k=%0d: got %b expected %b", k, a_serial, eb); end
         end
         checks++;
         if (a_done !== (k == 9)) begin errors++; $display("FAIL single_done k=%0d: got %b", k, a_done); end
         if (k == 1 || k == 11) begin
            checks++;
            if (a_busy !== (k == 1)) begin errors++; $display("FAIL single_busy k=%0d: got %b", k, a_busy); end
         end
      end
      checks++;
      if (a_exp.size() != 0) begin errors++; $display("FAIL single_leftover: got %0d bits expected 0", a_exp.size()); end
   endtask

   task automatic test_contention();
      int   exp_order[4] = '{0, 1, 0, 1};
      int   lo, started, dones, g;
      logic pf, eb;
      do_reset();
      a_en_next = 1'b1;
      a_q0.push_back(8'hF0); a_q0.push_back(8'hF0);
      a_q1.push_back(8'h0F); a_q1.push_back(8'h0F);
      lo = 0; started = 0; dones = 0; pf = 1'b0;
      for (int k = 0; k < 60; k++) begin
         a_cycle();
         if (a_frame) begin
            if (!pf) begin
               if (started > 0) begin
                  checks++;
                  if (lo != 3) begin errors++; $display("FAIL cont_gap: got %0d low cycles expected 3", lo); end
               end
               started++;
            end
            lo = 0;
            eb = 1'bx;
            if (a_exp.size() != 0) eb = a_exp.pop_front();
            checks++;
            if (a_serial !== eb) begin errors++; $display("FAIL cont_bit k=%0d: got %b expected %b", k, a_serial, eb); end
         end else begin
            lo++;
         end
         if (a_done) begin
            dones++;
            g = -1;
            if (a_exp_gid.size() != 0) g = a_exp_gid.pop_front();
            checks++;
            if (int'(a_gid) != g) begin errors++; $display("FAIL cont_gid: got %0d expected %0d", a_gid, g); end
         end
         pf = a_frame;
      end
      checks++;
      if (dones != 4) begin errors++; $display("FAIL cont_dones: got %0d expected 4", dones); end
      checks++;
      if (a_glog.size() != 4) begin errors++; $display("FAIL cont_grants: got %0d expected 4", a_glog.size()); end
      for (int i = 0; i < 4 && i < a_glog.size(); i++) begin
         checks++;
         if (a_glog[i] != exp_order[i]) begin
            errors++; $display("FAIL cont_order[%0d]: got %0d expected %0d", i, a_glog[i], exp_order[i]);
         end
      end
   endtask

   task automatic test_enable();
      int   dones;
      logic dropped, eb;
      do_reset();
      a_en_next = 1'b0;
      a_q0.push_back(8'hAA);
      a_q1.push_back(8'h55);
      for (int k = 0; k < 6; k++) begin
         a_cycle();
         checks++;
         if ({a_ready, a_busy} !== 3'b000) begin errors++; $display("FAIL en_off: got %b expected 000", {a_ready, a_busy}); end
      end
      a_en_next = 1'b1;
      dropped = 1'b0; dones = 0;
      for (int k = 0; k < 30; k++) begin
         a_cycle();
         if (dropped) begin
            checks++;
            if (a_ready !== 2'b00) begin errors++; $display("FAIL en_drop_ready k=%0d: got %b expected 00", k, a_ready); end
         end
         if (a_frame) begin
            if (!dropped) begin a_en_next = 1'b0; dropped = 1'b1; end
            eb = 1'bx;
            if (a_exp.size() != 0) eb = a_exp.pop_front();
            checks++;
            if (a_serial !== eb) begin errors++; $display("FAIL en_bit k=%0d: got %b expected %b", k, a_serial, eb); end
         end
         if (a_done) dones++;
      end
      checks++;
      if (dones != 1) begin errors++; $display("FAIL en_dones: got %0d expected 1", dones); end
      checks++;
      if (a_q1.size() != 1) begin errors++; $display("FAIL en_pending: got %0d words expected 1", a_q1.size()); end
      checks++;
      if (a_busy !== 1'b0) begin errors++; $display("FAIL en_busy: got %b expected 0", a_busy); end
   endtask

   task automatic test_reset_mid();
      int   nb, nd;
      logic hit;
      do_reset();
      a_en_next = 1'b1;
      a_q0.push_back(8'hFF);
      nb = 0; hit = 1'b0;
      for (int k = 0; k < 12 && !hit; k++) begin
         a_cycle();
         if (a_frame) begin
            nb++;
            if (nb == 5) begin
               #2 rstn = 1'b0;
               #1;
               hit = 1'b1;
               checks++;
               if ({a_frame, a_serial, a_busy, a_done} !== 4'b0000) begin
                  errors++; $display("FAIL rmid_async: got %b expected 0000", {a_frame, a_serial, a_busy, a_done});
               end
            end
         end
      end
      checks++;
      if (!hit) begin errors++; $display("FAIL rmid_reach: got %0d bits expected 5", nb); end
      a_exp.delete(); a_exp_gid.delete(); a_glog.delete();
      @(posedge clk);
      @(negedge clk); rstn = 1'b1;
      a_q0.push_back(8'h11);
      a_q1.push_back(8'h22);
      nd = 0;
      for (int k = 0; k < 8; k++) begin
         a_cycle();
         if (a_done) nd++;
      end
      checks++;
      if (nd != 0) begin errors++; $display("FAIL rmid_done: got %0d pulses expected 0", nd); end
      checks++;
      if (a_glog.size() == 0 || a_glog[0] != 0) begin
         errors++; $display("FAIL rmid_grant: got %0d grants, first not requester 0", a_glog.size());
      end
   endtask

   task automatic test_gap0();
      logic [7:0] words[3] = '{8'hA5, 8'h3C, 8'h81};
      logic       bq[$];
      int         wi, hi, lo, seen, dones;
      logic       eb;
      do_reset();
      b_en = 1'b1;
      wi = 0; hi = 0; lo = 0; seen = 0; dones = 0;
      for (int k = 0; k < 50; k++) begin
         @(posedge clk); #1;
         b_valid = {1'b0, (wi < 3)};
         b_data  = '0;
         if (wi < 3) b_data[7:0] = words[wi];
         @(negedge clk);
         if (b_valid[0] && b_ready[0]) begin
            for (int b = 7; b >= 0; b--) bq.push_back(words[wi][b]);
            wi++;
         end
         if (b_frame) begin
            if (hi == 0 && seen > 0) begin
               checks++;
               if (lo != 2) begin errors++; $display("FAIL gap0_low: got %0d expected 2", lo); end
            end
            lo = 0; hi++;
            eb = 1'bx;
            if (bq.size() != 0) eb = bq.pop_front();
            checks++;
            if (b_serial !== eb) begin errors++; $display("FAIL gap0_bit k=%0d: got %b expected %b", k, b_serial, eb); end
         end else begin
            if (hi > 0) begin
               checks++;
               if (hi != 8) begin errors++; $display("FAIL gap0_high: got %0d expected 8", hi); end
               seen++;
            end
            hi = 0; lo++;
         end
         if (b_done) begin
            dones++;
            checks++;
            if ({b_gid, b_ready[1]} !== 2'b00) begin errors++; $display("FAIL gap0_gid: got %b expected 00", {b_gid, b_ready[1]}); end
         end
      end
      checks++;
      if (dones != 3 || seen != 3) begin errors++; $display("FAIL gap0_count: got %0d dones %0d words expected 3", dones, seen); end
   endtask

   task automatic test_edge();
      logic [1:0] cw[3][2] = '{'{2'b10, 2'b01}, '{2'b11, 2'b00}, '{2'b01, 2'b10}};
      int         exp_order[6] = '{0, 1, 2, 0, 1, 2};
      int         idx[3] = '{0, 0, 0};
      int         glog[$];
      int         cg[$];
      logic       cq[$];
      logic       dq[$];
      logic [15:0] dw;
      int         g, nf;
      logic       eb, taken;
      do_reset();
      c_en = 1'b1;
      for (int k = 0; k < 60; k++) begin
         @(posedge clk); #1;
         for (int i = 0; i < 3; i++) begin
            c_valid[i] = (idx[i] < 2);
            c_data[i*2 +: 2] = 2'b00;
            if (idx[i] < 2) c_data[i*2 +: 2] = cw[i][idx[i]];
         end
         @(negedge clk);
         for (int i = 0; i < 3; i++) begin
            if (c_valid[i] && c_ready[i]) begin
               cq.push_back(cw[i][idx[i]][1]);
               cq.push_back(cw[i][idx[i]][0]);
               cg.push_back(i);
               glog.push_back(i);
               idx[i]++;
            end
         end
         if (c_frame) begin
            eb = 1'bx;
            if (cq.size() != 0) eb = cq.pop_front();
            checks++;
            if (c_serial !== eb) begin errors++; $display("FAIL edge2_bit k=%0d: got %b expected %b", k, c_serial, eb); end
         end
         if (c_done) begin
            g = -1;
            if (cg.size() != 0) g = cg.pop_front();
            checks++;
            if (int'(c_gid) != g) begin errors++; $display("FAIL edge2_gid: got %0d expected %0d", c_gid, g); end
         end
      end
      checks++;
      if (glog.size() != 6) begin errors++; $display("FAIL edge2_grants: got %0d expected 6", glog.size()); end
      for (int i = 0; i < 6 && i < glog.size(); i++) begin
         checks++;
         if (glog[i] != exp_order[i]) begin
            errors++; $display("FAIL edge2_order[%0d]: got %0d expected %0d", i, glog[i], exp_order[i]);
         end
      end
      // SIZE 16 word with a set bit at each end
      d_en = 1'b1; dw = 16'h8001; taken = 1'b0; nf = 0;
      for (int k = 0; k < 30; k++) begin
         @(posedge clk); #1;
         d_valid = {1'b0, !taken};
         d_data  = {16'h0000, dw};
         @(negedge clk);
         if (!taken && d_ready[0]) begin
            taken = 1'b1;
            for (int b = 15; b >= 0; b--) dq.push_back(dw[b]);
         end
         if (d_frame) begin
            nf++;
            eb = 1'bx;
            if (dq.size() != 0) eb = dq.pop_front();
            checks++;
            if (d_serial !== eb) begin errors++; $display("FAIL edge16_bit %0d: got %b expected %b", nf, d_serial, eb); end
         end
         if (d_done) begin
            checks++;
            if (nf != 16 || d_serial !== 1'b1 || d_gid !== 1'b0) begin
               errors++; $display("FAIL edge16_done: got bit %0d serial %b gid %0d expected 16 1 0", nf, d_serial, d_gid);
            end
         end
      end
      checks++;
      if (!taken || nf != 16) begin errors++; $display("FAIL edge16_frame: got %0d frame cycles expected 16", nf); end
      checks++;
      if ({b_busy, c_busy, d_busy} !== 3'b000) begin errors++; $display("FAIL edge_idle: got %b expected 000", {b_busy, c_busy, d_busy}); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_enable();
      test_reset_mid();
      test_gap0();
      test_edge();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
